// File: rtl/swar_keypad_ctrl_if.sv
// rtl/swar_keypad_ctrl_if.sv - key inputs and player-side outputs of the swar keypad controller
interface swar_keypad_ctrl_if;
    logic [6:0] key_raw;
    logic       play;
    logic [2:0] swar_select;
    logic       note_start;

    modport master (
        output key_raw,
        input  play,
        input  swar_select,
        input  note_start
    );

    modport slave (
        input  key_raw,
        output play,
        output swar_select,
        output note_start
    );
endinterface

// File: rtl/swar_keypad_ctrl.sv
// rtl/swar_keypad_ctrl.sv - synchronise, debounce and priority-encode seven swar keys into play/select
module swar_keypad_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int GAP_CYCLES      = 2500
) (
    input  logic                clk,
    input  logic                rst_n,
    swar_keypad_ctrl_if.slave   bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PLAYING, GAP} state_t;

    logic [6:0]    sync_1;
    logic [6:0]    key_s;
    logic [6:0]    stable;
    logic [CW-1:0] db_cnt [7];
    logic [GW-1:0] gap_cnt;
    state_t        state;
    logic          play_q;
    logic [2:0]    select_q;
    logic          note_start_q;
    logic          any_p;
    logic [2:0]    idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            key_s  <= '0;
        end else begin
            sync_1 <= bus.key_raw;
            key_s  <= sync_1;
        end
    end

    // A key's stable bit only follows key_s after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < 7; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (key_s[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= key_s[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Descending scan so the lowest held key overrides higher ones.
    always_comb begin
        idx   = 3'd0;
        any_p = |stable;
        for (int i = 6; i >= 0; i--) begin
            if (stable[i]) idx = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            play_q       <= 1'b0;
            select_q     <= 3'd0;
            note_start_q <= 1'b0;
            gap_cnt      <= '0;
        end else begin
            note_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_p) begin
                        select_q     <= idx;
                        play_q       <= 1'b1;
                        note_start_q <= 1'b1;
                        state        <= PLAYING;
                    end
                end
                PLAYING: begin
                    if (!any_p) begin
                        play_q <= 1'b0;
                        state  <= IDLE;
                    end else if (idx != select_q) begin
                        play_q  <= 1'b0;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (any_p) begin
                            select_q     <= idx;
                            play_q       <= 1'b1;
                            note_start_q <= 1'b1;
                            state        <= PLAYING;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    play_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.play        = play_q;
    assign bus.swar_select = select_q;
    assign bus.note_start  = note_start_q;
endmodule

// File: tb/tb_swar_keypad_ctrl.sv
// tb/tb_swar_keypad_ctrl.sv - scoreboard bench for swar_keypad_ctrl with short debounce and gap
module tb_swar_keypad_ctrl;
    localparam int DB  = 4;
    localparam int GAP = 3;
    localparam int LAT = 2 + DB + 1;

    typedef struct {
        int sel;
        int stamp;
    } note_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   t_drv;
    note_t note_q[$];
    int    fall_q[$];
    logic  prev_play = 1'b0;
    logic [2:0] prev_sel = 3'd0;

    swar_keypad_ctrl_if kif();

    swar_keypad_ctrl #(.DEBOUNCE_CYCLES(DB), .GAP_CYCLES(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_keys(input logic [6:0] k);
        @(posedge clk);
        #1;
        kif.key_raw = k;
        t_drv = cyc;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic exp_note(input int sel, input int stamp);
        note_t e;
        e.sel   = sel;
        e.stamp = stamp;
        note_q.push_back(e);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_play"}, int'(kif.play), 0);
        check({tag, "_select"}, int'(kif.swar_select), 0);
        check({tag, "_note_start"}, int'(kif.note_start), 0);
    endtask

    // Monitor: sampled on the falling edge, compares DUT events against the queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_play = 1'b0;
            prev_sel  = kif.swar_select;
        end else begin
            if (kif.note_start) begin
                check("note_start_on_rise", int'(kif.play && !prev_play), 1);
                if (note_q.size() == 0) begin
                    check("unexpected_note_start", cyc, -1);
                end else begin
                    note_t e;
                    e = note_q.pop_front();
                    check("note_select", int'(kif.swar_select), e.sel);
                    check("note_cycle", cyc, e.stamp);
                end
            end
            if (prev_play && kif.play) check("select_steady", int'(kif.swar_select), int'(prev_sel));
            if (prev_play && !kif.play) begin
                if (fall_q.size() == 0) check("unexpected_play_fall", cyc, -1);
                else check("play_fall_cycle", cyc, fall_q.pop_front());
            end
            prev_play = kif.play;
            prev_sel  = kif.swar_select;
        end
    end

    initial begin
        rst_n       = 1'b0;
        kif.key_raw = 7'd0;
        #2;
        check_outputs_zero("reset");
        #20;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cycles(3);

        // Clean press of key2 then release.
        set_keys(7'b0000100); exp_note(2, t_drv + LAT);
        wait_cycles(12);
        set_keys(7'b0000000); fall_q.push_back(t_drv + LAT);
        wait_cycles(12);

        // Key0 bounces (2-high, 1-low, 3-high, 2-low) before settling.
        set_keys(7'b0000001); wait_cycles(1);
        set_keys(7'b0000000);
        set_keys(7'b0000001); wait_cycles(2);
        set_keys(7'b0000000); wait_cycles(1);
        set_keys(7'b0000001); exp_note(0, t_drv + LAT);
        wait_cycles(12);
        set_keys(7'b0000000); fall_q.push_back(t_drv + LAT);
        wait_cycles(12);

        // Hold key3, add key1: three-cycle gap then select 1.
        set_keys(7'b0001000); exp_note(3, t_drv + LAT);
        wait_cycles(10);
        set_keys(7'b0001010); fall_q.push_back(t_drv + LAT); exp_note(1, t_drv + LAT + GAP);
        wait_cycles(15);
        set_keys(7'b0000000); fall_q.push_back(t_drv + LAT);
        wait_cycles(12);

        // Key4 and key6 together, then drop key4.
        set_keys(7'b1010000); exp_note(4, t_drv + LAT);
        wait_cycles(12);
        set_keys(7'b1000000); fall_q.push_back(t_drv + LAT); exp_note(6, t_drv + LAT + GAP);
        wait_cycles(15);

        // Release all: select holds its last value.
        set_keys(7'b0000000); fall_q.push_back(t_drv + LAT);
        wait_cycles(12);
        check("hold_select", int'(kif.swar_select), 6);
        check("idle_play", int'(kif.play), 0);

        // Reset mid-note, release with key held.
        set_keys(7'b0000100); exp_note(2, t_drv + LAT);
        wait_cycles(10);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_outputs_zero("reset_mid_note");
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_note(2, cyc + LAT);
        wait_cycles(12);

        // Reset mid-gap, release with both keys held.
        set_keys(7'b0000101); fall_q.push_back(t_drv + LAT);
        wait_cycles(8);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("reset_mid_gap");
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_note(0, cyc + LAT);
        wait_cycles(12);
        set_keys(7'b0000000); fall_q.push_back(t_drv + LAT);

        for (int i = 0; i < 50 && (note_q.size() != 0 || fall_q.size() != 0); i++) @(posedge clk);
        wait_cycles(2);
        check("pending_notes", note_q.size(), 0);
        check("pending_falls", fall_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
